// File: rtl/bouncing_shr_if.sv
// Bus bundle for the bouncing shift register: mode/serial-in from the controller, LED bar back.
// With BOUNCING_SHR_DIR_OUT_EN defined the bundle also carries the current bounce direction.
interface bouncing_shr_if #(
  parameter int N_BIT = 8
);
  logic             en;
  logic             sin;
  logic [N_BIT-1:0] pout;
`ifdef BOUNCING_SHR_DIR_OUT_EN
  logic             dir_out;
`endif

`ifdef BOUNCING_SHR_DIR_OUT_EN
  modport master (output en, output sin, input pout, input dir_out);
  modport slave  (input en, input sin, output pout, output dir_out);
`else
  modport master (output en, output sin, input pout);
  modport slave  (input en, input sin, output pout);
`endif
endinterface

// File: rtl/bouncing_shr.sv
// Knight-Rider shift register: serial load while en=0, bounce between the ends while en=1.
// Optional macro BOUNCING_SHR_DIR_OUT_EN exposes the direction flag as dir_out (1 = RIGHT).
module bouncing_shr #(
  parameter int N_BIT = 8
) (
  input logic           clk,
  input logic           rst,
  bouncing_shr_if.slave bus
);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  dir_t             dir;
  dir_t             dir_nxt;
  logic [N_BIT-1:0] shr;
  logic [N_BIT-1:0] shr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shr <= '0;
      dir <= LEFT;
    end else begin
      shr <= shr_nxt;
      dir <= dir_nxt;
    end
  end

  // The turn and the first step back happen on the same edge, so each end is lit for one cycle.
  always_comb begin
    shr_nxt = shr;
    dir_nxt = dir;
    if (!bus.en) begin
      shr_nxt = {shr[N_BIT-2:0], bus.sin};
      dir_nxt = LEFT;
    end else begin
      case (dir)
        LEFT: begin
          if (shr[N_BIT-1]) begin
            dir_nxt = RIGHT;
            shr_nxt = shr >> 1;
          end else begin
            shr_nxt = shr << 1;
          end
        end
        RIGHT: begin
          if (shr[0]) begin
            dir_nxt = LEFT;
            shr_nxt = shr << 1;
          end else begin
            shr_nxt = shr >> 1;
          end
        end
        default: begin
          shr_nxt = shr;
          dir_nxt = dir;
        end
      endcase
    end
  end

  assign bus.pout = shr;
`ifdef BOUNCING_SHR_DIR_OUT_EN
  assign bus.dir_out = (dir == RIGHT);
`endif

endmodule

// File: tb/tb_bouncing_shr.sv
// Directed and random checks of bouncing_shr (N_BIT=6) against an arithmetic reference model.
module tb_bouncing_shr;
  localparam int N = 6;
  localparam int MOD = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Reference state: register value as an integer and a "moving toward LSB" flag.
  int m_val   = 0;
  bit m_right = 1'b0;

  int bounce_exp[11] = '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2};

  bouncing_shr_if #(.N_BIT(N)) bus ();

  bouncing_shr #(.N_BIT(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] mv;
    mv = m_val[N-1:0];
    check(tag, {26'd0, bus.pout}, {26'd0, mv});
`ifdef BOUNCING_SHR_DIR_OUT_EN
    check({tag, "_dir"}, {31'd0, bus.dir_out}, {31'd0, m_right});
`endif
  endtask

  function automatic void model_edge(input bit e, input bit s);
    if (!e) begin
      m_val   = ((m_val * 2) + int'(s)) % MOD;
      m_right = 1'b0;
    end else if (!m_right) begin
      if (m_val >= HALF) begin
        m_right = 1'b1;
        m_val   = m_val / 2;
      end else begin
        m_val = (m_val * 2) % MOD;
      end
    end else begin
      if ((m_val % 2) == 1) begin
        m_right = 1'b0;
        m_val   = (m_val * 2) % MOD;
      end else begin
        m_val = m_val / 2;
      end
    end
  endfunction

  // Called during the low phase; drives inputs, takes one rising edge, checks, returns at negedge.
  task automatic step(input bit e, input bit s, input string tag);
    bus.en  = e;
    bus.sin = s;
    @(posedge clk);
    #1;
    model_edge(e, s);
    check_model(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between edges, held across one rising edge.
  task automatic async_reset(input string tag);
    #1;
    rst = 1'b0;
    #1;
    m_val   = 0;
    m_right = 1'b0;
    check_model({tag, "_async"});
    bus.en  = 1'($urandom);
    bus.sin = 1'($urandom);
    @(posedge clk);
    #1;
    check_model({tag, "_held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.en  = 1'($urandom);
    bus.sin = 1'($urandom);
    #1;
    check_model("reset_t0");
    for (int i = 0; i < 4; i++) begin
      bus.en  = 1'($urandom);
      bus.sin = 1'($urandom);
      @(posedge clk);
      #1;
      check_model("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;

    // Serial load
    step(1'b0, 1'b1, "load1");
    check("load1_const", {26'd0, bus.pout}, 32'h01);
    step(1'b0, 1'b0, "load2");
    check("load2_const", {26'd0, bus.pout}, 32'h02);
    step(1'b0, 1'b0, "load3");
    check("load3_const", {26'd0, bus.pout}, 32'h04);

    // Single bit bounce from 000001
    async_reset("pre_bounce");
    step(1'b0, 1'b1, "bounce_load");
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, "bounce");
      check("bounce_const", {26'd0, bus.pout}, bounce_exp[i]);
    end

    // sin toggling in bounce mode must not matter
    async_reset("pre_sin_ign");
    step(1'b0, 1'b1, "sin_ign_load");
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'(i % 2), "sin_ign");
      check("sin_ign_const", {26'd0, bus.pout}, bounce_exp[i]);
    end

    // Reset mid-bounce at 001000
    async_reset("pre_mid");
    step(1'b0, 1'b1, "mid_load");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "mid_bounce");
    check("mid_at_8", {26'd0, bus.pout}, 32'h08);
    async_reset("mid_reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, "mid_after");
      check("mid_after_const", {26'd0, bus.pout}, 32'h00);
    end

    // Load while moving RIGHT clears direction
    async_reset("pre_dirclr");
    step(1'b0, 1'b1, "dirclr_load");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "dirclr_bounce");
    check("dirclr_at_16", {26'd0, bus.pout}, 32'h10);
    step(1'b0, 1'b1, "dirclr_reload");
    check("dirclr_33", {26'd0, bus.pout}, 32'h21);
    step(1'b1, 1'b0, "dirclr_flip");
    check("dirclr_16", {26'd0, bus.pout}, 32'h10);
    step(1'b1, 1'b0, "dirclr_next");
    check("dirclr_8", {26'd0, bus.pout}, 32'h08);

    // Random traffic: mostly bouncing, some loading, occasional async reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_reset");
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
